// File: rtl/fft_pkg.sv
// Shared definitions for the FFT butterfly datapath: default sample format,
// a packed complex sample type and the signed saturation helper.
package fft_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_FRAC  = 8;

   typedef struct packed {
      logic signed [DEF_WIDTH-1:0] re;
      logic signed [DEF_WIDTH-1:0] im;
   } cplx_t;

   // Clamp a sign-extended value into the range of a w-bit two's complement number.
   function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v,
                                                       input int               w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/fft_butterfly_stage_if.sv
// Butterfly stage bus: input pair handshake, twiddle addressing back to the
// complex multiplier, and the output result handshake with frame/overflow flags.
interface fft_butterfly_stage_if #(
   parameter int N     = 8,
   parameter int WIDTH = 16
);
   localparam int LOGN = $clog2(N);
   localparam int TW_W = LOGN - 1;
   localparam int SW   = $clog2(LOGN);

   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] a_re;
   logic signed [WIDTH-1:0] a_im;
   logic signed [WIDTH-1:0] wb_re;
   logic signed [WIDTH-1:0] wb_im;
   logic [TW_W-1:0]         tw_idx;
   logic [SW-1:0]           stage_idx;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] x_re;
   logic signed [WIDTH-1:0] x_im;
   logic signed [WIDTH-1:0] y_re;
   logic signed [WIDTH-1:0] y_im;
   logic                    out_last;
   logic                    ovf;

   modport master (
      output in_valid, a_re, a_im, wb_re, wb_im, out_ready,
      input  in_ready, tw_idx, stage_idx, out_valid,
             x_re, x_im, y_re, y_im, out_last, ovf
   );

   modport slave (
      input  in_valid, a_re, a_im, wb_re, wb_im, out_ready,
      output in_ready, tw_idx, stage_idx, out_valid,
             x_re, x_im, y_re, y_im, out_last, ovf
   );

endinterface

// File: rtl/fft_bfly_sat.sv
// Scales (optionally) and saturates one WIDTH+1 bit butterfly sum to WIDTH bits.
// Build option: define FFT_BFLY_SCALE_EN to halve every sum (floor) before the
// range check, which makes saturation impossible.
module fft_bfly_sat
   import fft_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic signed [WIDTH:0]   sum,
   output logic signed [WIDTH-1:0] res,
   output logic                    sat
);

   logic signed [WIDTH:0] scaled_s;
   logic signed [31:0]    ext_s;
   logic signed [31:0]    clip_s;

   // Optional halving, sign extension and clamp of the sum.
   always_comb begin
`ifdef FFT_BFLY_SCALE_EN
      scaled_s = sum >>> 1;
`else
      scaled_s = sum;
`endif
      ext_s  = 32'(scaled_s);
      clip_s = sat_to_width(ext_s, WIDTH);
      sat    = (clip_s != ext_s);
      res    = WIDTH'(clip_s);
   end

endmodule

// File: rtl/fft_butterfly_stage.sv
// Radix-2 butterfly stage: X = A + WB, Y = A - WB, two-stage pipeline with a
// single global advance, frame/stage counters driving the twiddle index, a
// last-of-frame tag and a sticky overflow flag cleared by each new frame.
// Build option: FFT_BFLY_SCALE_EN (see fft_bfly_sat) halves results instead of saturating.
module fft_butterfly_stage
   import fft_pkg::*;
#(
   parameter int N     = 8,
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC
) (
   input logic                  clk,
   input logic                  rst,
   fft_butterfly_stage_if.slave bus
);

   localparam int LOGN = $clog2(N);
   localparam int BW   = LOGN - 1;
   localparam int SW   = $clog2(LOGN);
   localparam logic [BW-1:0] BFLY_LAST  = BW'(N / 2 - 1);
   localparam logic [SW-1:0] STAGE_LAST = SW'(LOGN - 1);

   generate
      if ((N < 4) || (N > 1024) || ((N & (N - 1)) != 0) || (FRAC < 0) || (FRAC >= WIDTH)) begin : g_bad_param
         $error("fft_butterfly_stage: illegal N, WIDTH or FRAC");
      end
   endgenerate

   logic                    en_s;
   logic                    in_ready_s;
   logic                    acc_s;
   logic [BW-1:0]           tw_s;
   logic [BW-1:0]           bfly_cnt_r;
   logic [SW-1:0]           stage_idx_r;

   logic signed [WIDTH:0]   sum_x_re_s, sum_x_im_s, sum_y_re_s, sum_y_im_s;
   logic signed [WIDTH:0]   s1_x_re_r, s1_x_im_r, s1_y_re_r, s1_y_im_r;
   logic                    s1_valid_r;
   logic                    s1_last_r;
   logic                    s1_first_r;

   logic signed [WIDTH-1:0] sat_x_re_s, sat_x_im_s, sat_y_re_s, sat_y_im_s;
   logic                    hit_x_re_s, hit_x_im_s, hit_y_re_s, hit_y_im_s;
   logic                    any_sat_s;

   logic signed [WIDTH-1:0] x_re_r, x_im_r, y_re_r, y_im_r;
   logic                    out_valid_r;
   logic                    out_last_r;
   logic                    ovf_r;

   // Global pipeline advance and input handshake; nothing is accepted while in reset.
   always_comb begin
      en_s       = !out_valid_r || bus.out_ready;
      in_ready_s = en_s && !rst;
      acc_s      = bus.in_valid && in_ready_s;
   end

   // Twiddle index: butterfly position within its group, scaled to the N-point table.
   always_comb begin
      logic [31:0] mask_v;
      logic [31:0] shamt_v;
      mask_v  = (32'd1 << stage_idx_r) - 32'd1;
      shamt_v = 32'(LOGN - 1) - 32'(stage_idx_r);
      tw_s    = BW'((32'(bfly_cnt_r) & mask_v) << shamt_v);
   end

   // Full-precision sums, one guard bit so nothing is lost before scaling/saturation.
   always_comb begin
      sum_x_re_s = {bus.a_re[WIDTH-1], bus.a_re} + {bus.wb_re[WIDTH-1], bus.wb_re};
      sum_x_im_s = {bus.a_im[WIDTH-1], bus.a_im} + {bus.wb_im[WIDTH-1], bus.wb_im};
      sum_y_re_s = {bus.a_re[WIDTH-1], bus.a_re} - {bus.wb_re[WIDTH-1], bus.wb_re};
      sum_y_im_s = {bus.a_im[WIDTH-1], bus.a_im} - {bus.wb_im[WIDTH-1], bus.wb_im};
   end

   // Butterfly and stage counters step once per accepted pair and wrap at frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         bfly_cnt_r  <= '0;
         stage_idx_r <= '0;
      end else if (acc_s) begin
         if (bfly_cnt_r == BFLY_LAST) begin
            bfly_cnt_r  <= '0;
            stage_idx_r <= (stage_idx_r == STAGE_LAST) ? '0 : stage_idx_r + SW'(1);
         end else begin
            bfly_cnt_r <= bfly_cnt_r + BW'(1);
         end
      end
   end

   // Stage 1: capture the raw sums plus frame-position tags of the accepted pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_first_r <= 1'b0;
         s1_x_re_r  <= '0;
         s1_x_im_r  <= '0;
         s1_y_re_r  <= '0;
         s1_y_im_r  <= '0;
      end else if (en_s) begin
         s1_valid_r <= acc_s;
         if (acc_s) begin
            s1_x_re_r  <= sum_x_re_s;
            s1_x_im_r  <= sum_x_im_s;
            s1_y_re_r  <= sum_y_re_s;
            s1_y_im_r  <= sum_y_im_s;
            s1_last_r  <= (bfly_cnt_r == BFLY_LAST) && (stage_idx_r == STAGE_LAST);
            s1_first_r <= (bfly_cnt_r == '0) && (stage_idx_r == '0);
         end
      end
   end

   fft_bfly_sat #(.WIDTH(WIDTH)) u_sat_x_re (.sum(s1_x_re_r), .res(sat_x_re_s), .sat(hit_x_re_s));
   fft_bfly_sat #(.WIDTH(WIDTH)) u_sat_x_im (.sum(s1_x_im_r), .res(sat_x_im_s), .sat(hit_x_im_s));
   fft_bfly_sat #(.WIDTH(WIDTH)) u_sat_y_re (.sum(s1_y_re_r), .res(sat_y_re_s), .sat(hit_y_re_s));
   fft_bfly_sat #(.WIDTH(WIDTH)) u_sat_y_im (.sum(s1_y_im_r), .res(sat_y_im_s), .sat(hit_y_im_s));

   // Any component of the butterfly in stage 1 clipping.
   always_comb begin
      any_sat_s = hit_x_re_s | hit_x_im_s | hit_y_re_s | hit_y_im_s;
   end

   // Stage 2: registered results; the overflow flag restarts with a frame's first result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         ovf_r       <= 1'b0;
         x_re_r      <= '0;
         x_im_r      <= '0;
         y_re_r      <= '0;
         y_im_r      <= '0;
      end else if (en_s) begin
         out_valid_r <= s1_valid_r;
         out_last_r  <= s1_valid_r && s1_last_r;
         if (s1_valid_r) begin
            x_re_r <= sat_x_re_s;
            x_im_r <= sat_x_im_s;
            y_re_r <= sat_y_re_s;
            y_im_r <= sat_y_im_s;
            ovf_r  <= (s1_first_r ? 1'b0 : ovf_r) | any_sat_s;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.tw_idx    = tw_s;
   assign bus.stage_idx = stage_idx_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_last  = out_last_r;
   assign bus.ovf       = ovf_r;
   assign bus.x_re      = x_re_r;
   assign bus.x_im      = x_im_r;
   assign bus.y_re      = y_re_r;
   assign bus.y_im      = y_im_r;

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Self-checking bench for fft_butterfly_stage (N=8, WIDTH=16): directed vectors
// with literal expectations plus a transaction-level reference model.
module tb_fft_butterfly_stage;
   import fft_pkg::*;

   localparam int N     = 8;
   localparam int WIDTH = 16;
   localparam int LOGN  = 3;
   localparam int HALF  = N / 2;
   localparam int FRAME = HALF * LOGN;

`ifdef FFT_BFLY_SCALE_EN
   localparam int T1_XR = 'h00C0;
   localparam int T1_YR = 'h0040;
   localparam int T2_XR = 'h7000;
   localparam int T2_XI = -28672;
   localparam int T2_OVF = 0;
`else
   localparam int T1_XR = 'h0180;
   localparam int T1_YR = 'h0080;
   localparam int T2_XR = 32767;
   localparam int T2_XI = -32768;
   localparam int T2_OVF = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft_butterfly_stage_if #(.N(N), .WIDTH(WIDTH)) bus ();

   fft_butterfly_stage #(.N(N), .WIDTH(WIDTH), .FRAC(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int xr; int xi; int yr; int yi;
      bit last; bit first; bit sat;
   } exp_t;

   exp_t exp_q[$];
   int   k         = 0;
   bit   m_ovf     = 1'b0;
   int   deliv_cnt = 0;
   int   last_pos  = 0;
   int   last_cnt  = 0;
   bit   hold_pend = 1'b0;
   int   snap_xr, snap_xi, snap_yr, snap_yi, snap_last;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // Reference arithmetic: optional floor-halving, then clamp to 16-bit signed.
   function automatic int msat(input int s, inout bit hit);
      int v;
      v = s;
`ifdef FFT_BFLY_SCALE_EN
      v = v >>> 1;
`endif
      if (v > 32767) begin
         hit = 1'b1;
         return 32767;
      end
      if (v < -32768) begin
         hit = 1'b1;
         return -32768;
      end
      return v;
   endfunction

   function automatic cplx_t mk(input int re, input int im);
      cplx_t c;
      c.re = 16'(re);
      c.im = 16'(im);
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input cplx_t a, input cplx_t b);
      bus.in_valid = 1'b1;
      bus.a_re     = a.re;
      bus.a_im     = a.im;
      bus.wb_re    = b.re;
      bus.wb_im    = b.im;
   endtask

   // Model and compare: predicts each accepted pair's result, checks every drain and hold.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         k         = 0;
         m_ovf     = 1'b0;
         deliv_cnt = 0;
         last_pos  = 0;
         last_cnt  = 0;
         hold_pend = 1'b0;
      end else begin
         check("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
         if (hold_pend) begin
            check("hold_valid", int'(bus.out_valid), 1);
            check("hold_x_re", int'(bus.x_re), snap_xr);
            check("hold_x_im", int'(bus.x_im), snap_xi);
            check("hold_y_re", int'(bus.y_re), snap_yr);
            check("hold_y_im", int'(bus.y_im), snap_yi);
            check("hold_last", int'(bus.out_last), snap_last);
         end
         hold_pend = bus.out_valid && !bus.out_ready;
         snap_xr   = int'(bus.x_re);
         snap_xi   = int'(bus.x_im);
         snap_yr   = int'(bus.y_re);
         snap_yi   = int'(bus.y_im);
         snap_last = int'(bus.out_last);

         if (bus.out_valid && bus.out_ready) begin
            exp_t e;
            deliv_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: actual result %0d delivered, required none", deliv_cnt);
            end else begin
               e = exp_q.pop_front();
               check("x_re", int'(bus.x_re), e.xr);
               check("x_im", int'(bus.x_im), e.xi);
               check("y_re", int'(bus.y_re), e.yr);
               check("y_im", int'(bus.y_im), e.yi);
               check("out_last", int'(bus.out_last), int'(e.last));
               m_ovf = (e.first ? 1'b0 : m_ovf) | e.sat;
               check("ovf", int'(bus.ovf), int'(m_ovf));
            end
            if (bus.out_last) begin
               last_pos = deliv_cnt;
               last_cnt++;
            end
         end

         if (bus.in_valid && bus.in_ready) begin
            exp_t e;
            int   bf, st, tw, ar, ai, br, bi;
            bit   hit;
            bf  = k % HALF;
            st  = k / HALF;
            tw  = (bf % (1 << st)) << (LOGN - 1 - st);
            check("tw_idx", int'(bus.tw_idx), tw);
            check("stage_idx", int'(bus.stage_idx), st);
            ar  = int'(bus.a_re);
            ai  = int'(bus.a_im);
            br  = int'(bus.wb_re);
            bi  = int'(bus.wb_im);
            hit = 1'b0;
            e.xr    = msat(ar + br, hit);
            e.xi    = msat(ai + bi, hit);
            e.yr    = msat(ar - br, hit);
            e.yi    = msat(ai - bi, hit);
            e.sat   = hit;
            e.first = (k == 0);
            e.last  = (k == FRAME - 1);
            exp_q.push_back(e);
            k = (k + 1) % FRAME;
         end
      end
   end

   // Run-time bound so a stuck pipeline still ends the run.
   initial begin
      #100000;
      $display("FAIL watchdog: actual time limit reached, required finish before it");
      $fatal(1, "watchdog expired");
   end

   int tw_lit [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   int st_lit [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

   // Directed stimulus sequence.
   initial begin
      int base;
      int idx;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a_re = '0; bus.a_im = '0; bus.wb_re = '0; bus.wb_im = '0;

      // Reset state
      tick();
      check("rst_in_ready", int'(bus.in_ready), 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_ovf", int'(bus.ovf), 0);
      check("rst_x_re", int'(bus.x_re), 0);
      check("rst_y_im", int'(bus.y_im), 0);
      check("rst_out_last", int'(bus.out_last), 0);
      check("post_rst_in_ready", int'(bus.in_ready), 1);
      tick();

      // Unscaled sum/difference and latency
      drive(mk('h0100, 0), mk('h0080, 0));
      tick();
      bus.in_valid = 1'b0;
      check("lat_early_valid", int'(bus.out_valid), 0);
      tick();
      check("t1_valid", int'(bus.out_valid), 1);
      check("t1_x_re", int'(bus.x_re), T1_XR);
      check("t1_x_im", int'(bus.x_im), 0);
      check("t1_y_re", int'(bus.y_re), T1_YR);
      check("t1_y_im", int'(bus.y_im), 0);
      check("t1_ovf", int'(bus.ovf), 0);

      // Saturation
      drive(mk('h7000, 'h9000), mk('h7000, 'h9000));
      tick();
      bus.in_valid = 1'b0;
      tick();
      check("t2_valid", int'(bus.out_valid), 1);
      check("t2_x_re", int'(bus.x_re), T2_XR);
      check("t2_x_im", int'(bus.x_im), T2_XI);
      check("t2_y_re", int'(bus.y_re), 0);
      check("t2_y_im", int'(bus.y_im), 0);
      check("t2_ovf", int'(bus.ovf), T2_OVF);
      tick();

      // Counters over one full frame, back to back
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive(mk(i * 300 - 1000, 50 * i), mk(-(i * 37), 1000 - i * 90));
         #1;
         check("cnt_in_ready", int'(bus.in_ready), 1);
         check("cnt_tw_lit", int'(bus.tw_idx), tw_lit[i]);
         check("cnt_stage_lit", int'(bus.stage_idx), st_lit[i]);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      repeat (3) tick();
      check("frame_results", deliv_cnt, 12);
      check("last_position", last_pos, 12);
      check("last_count", last_cnt, 1);

      // Backpressure mid-stream
      base = deliv_cnt;
      idx  = 0;
      for (int c = 0; c < 20; c++) begin
         bus.out_ready = !(c >= 3 && c < 8);
         if (idx < 6) begin
            drive(mk(idx * 6144 - 16384, 768 * idx), mk(20000, -1792 * idx));
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) idx++;
         if (bus.out_valid && !bus.out_ready) check("stall_in_ready", int'(bus.in_ready), 0);
         tick();
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      check("bp_accepted", idx, 6);
      check("bp_delivered", deliv_cnt - base, 6);
      check("bp_queue_empty", exp_q.size(), 0);

      // Reset in the middle of a frame
      for (int i = 0; i < 5; i++) begin
         if (i == 0) drive(mk('h7000, 0), mk('h7000, 0));
         else        drive(mk(10 * i, -5 * i), mk(3 * i, 7));
         tick();
      end
      bus.in_valid = 1'b0;
      check("pre_rst_ovf", int'(bus.ovf), T2_OVF);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      check("mid_rst_out_valid", int'(bus.out_valid), 0);
      check("mid_rst_ovf", int'(bus.ovf), 0);
      rst = 1'b0;
      drive(mk(1234, -4321), mk(-100, 200));
      #1;
      check("mid_rst_in_ready_after", int'(bus.in_ready), 1);
      check("mid_rst_tw", int'(bus.tw_idx), 0);
      check("mid_rst_stage", int'(bus.stage_idx), 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) tick();
      check("mid_rst_delivered", deliv_cnt, 1);
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_butterfly_stage.md
FFT_BUTTERFLY_STAGE -- requirements
Module: fft_butterfly_stage

Interface
REQ-001 SHALL have parameter N, default 8: FFT points, power of two, 4..1024; LOGN = log2(N).
REQ-002 SHALL have parameter WIDTH, default 16: signed sample width; FRAC, default 8: Q-format fraction bits.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: in_valid in 1; in_ready out 1; a_re, a_im in WIDTH signed, top input A; wb_re, wb_im in WIDTH signed, twiddle product W*B from the complex multiplier.
REQ-005 SHALL have ports: tw_idx out LOGN-1, twiddle index for the multiplier's current pair; stage_idx out ceil(log2 LOGN), current FFT stage.
REQ-006 SHALL have ports: out_valid out 1; out_ready in 1; x_re, x_im, y_re, y_im out WIDTH signed; out_last out 1, last butterfly of frame; ovf out 1, sticky overflow.

Function
REQ-007 SHALL compute X = A + WB and Y = A - WB per component at WIDTH+1 bits, no truncation before scaling/saturation.
REQ-008 SHALL be a 2-stage pipeline: stage 1 registers the 17-bit sums; stage 2 registers scaled/saturated results; latency 2 cycles from input handshake to out_valid with out_ready held high.
REQ-009 SHALL use global advance en = !out_valid || out_ready; in_ready = en; both stages shift only when en=1.
REQ-010 SHALL hold all output data, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-011 SHALL accept input only on in_valid && in_ready; data presented without a handshake is ignored.
REQ-012 SHALL keep counters bfly_cnt (0..N/2-1) and stage_idx (0..LOGN-1), advancing only on input handshake; bfly_cnt wraps to 0 and stage_idx increments; after the final butterfly of stage LOGN-1 both wrap to 0.
REQ-013 SHALL drive tw_idx combinationally = (bfly_cnt mod 2^stage_idx) << (LOGN-1-stage_idx).
REQ-014 SHALL tag the pair accepted at bfly_cnt=N/2-1, stage_idx=LOGN-1 and deliver out_last=1 with its result; out_last=0 otherwise.
REQ-015 SHALL set ovf when any output component saturates; ovf holds until reset or acceptance of the first butterfly of a new frame (bfly_cnt=0, stage_idx=0), which clears it in the same cycle unless that butterfly also saturates.
REQ-016 SHALL, on simultaneous output drain and input accept, do both in one cycle (full throughput, one butterfly per clock).

Reset
REQ-017 SHALL, when rst=1 at a clock edge, clear out_valid, internal stage-1 valid, out_last, ovf, bfly_cnt, stage_idx to 0 and zero x/y outputs; in-flight data discarded.
REQ-018 SHALL, during reset-asserted cycles, drive in_ready=0; in_ready follows REQ-009 from the first cycle after rst deasserts.
REQ-019 SHALL treat reset mid-frame identically to REQ-017; the next accepted pair is butterfly 0 of stage 0.

Configuration
REQ-020 SHALL, with FFT_BFLY_SCALE_EN defined, arithmetically shift each 17-bit sum right by 1 (truncate toward minus infinity) before the saturation check; ovf can then never set.
REQ-021 SHALL, without FFT_BFLY_SCALE_EN, saturate each 17-bit sum to [-2^(WIDTH-1), 2^(WIDTH-1)-1].

Structure
REQ-022 SHALL place WIDTH, FRAC defaults, a packed complex typedef (re, im) and a saturate function in shared package fft_pkg.
REQ-023 SHALL implement scaling/saturation of one component in sub-module fft_bfly_sat, instanced four times.

Verification
REQ-024 Unscaled: A=(0x0100,0x0000), WB=(0x0080,0x0000) -> after 2 cycles X=(0x0180,0x0000), Y=(0x0080,0x0000), ovf=0.
REQ-025 Saturation: A=(0x7000,0x9000), WB=(0x7000,0x9000) -> X=(0x7FFF,0x8000), Y=(0,0), ovf=1; with FFT_BFLY_SCALE_EN X=(0x7000,0x9000), ovf=0.
REQ-026 Counters N=8: 12 back-to-back handshakes -> tw_idx 0,0,0,0, 0,2,0,2, 0,1,2,3; stage_idx 0x4,1x4,2x4; out_last=1 only on 12th result.
REQ-027 Backpressure: stream 6 pairs, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while full, outputs stable, all 6 results delivered in order, none lost or duplicated.
REQ-028 Reset mid-frame: assert rst after 5 handshakes -> out_valid=0, ovf=0 next cycle; next accepted pair gets tw_idx=0, stage_idx=0.
